// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the cascaded clock-enable generator.
// Build option CLKDIV_IMM_LOAD_EN adds an immediate divisor load path.
package clkdiv_pkg;

   localparam int unsigned CLKDIV_MAX_CH = 8;
   localparam int unsigned CLKDIV_DIV_W  = 24;

   typedef logic [CLKDIV_DIV_W-1:0] div_t;

   // Channel-select width: one spare bit so out-of-range indices are representable.
   function automatic int unsigned wr_ch_w(input int unsigned num_ch);
      return $clog2(num_ch) + 1;
   endfunction

endpackage

// File: rtl/clkdiv_stage.sv
// One divider stage: counts input enables, emits a tick and a square wave.
// Build option CLKDIV_IMM_LOAD_EN adds the wr_imm immediate-load input.
module clkdiv_stage
   import clkdiv_pkg::*;
#(
   parameter int unsigned DIV_W = CLKDIV_DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_en,
   input  logic             wr_hit,
`ifdef CLKDIV_IMM_LOAD_EN
   input  logic             wr_imm,
`endif
   input  logic [DIV_W-1:0] wr_div,
   input  logic [DIV_W-1:0] rst_div,
   output logic             tick,
   output logic             sq
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] active_q, active_d;
   logic [DIV_W-1:0] shadow_q, shadow_d;
   logic             pend_q, pend_d;
   logic             tick_q, tick_d;
   logic             sq_q, sq_d;
   logic             div_zero_c;
   logic             term_c;
   logic             imm_c;

   assign div_zero_c = (active_q == '0);
   assign term_c     = in_en && !div_zero_c && (cnt_q == active_q - DIV_W'(1));

`ifdef CLKDIV_IMM_LOAD_EN
   assign imm_c = wr_hit && wr_imm;
`else
   assign imm_c = 1'b0;
`endif

   // Next-state: new divisors only take effect where a period boundary makes it glitch-free.
   always_comb begin
      cnt_d    = cnt_q;
      active_d = active_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      tick_d   = 1'b0;
      sq_d     = sq_q;

      if (wr_hit) begin
         shadow_d = wr_div;
         pend_d   = 1'b1;
      end

      if (imm_c) begin
         active_d = wr_div;
         cnt_d    = '0;
         pend_d   = 1'b0;
      end else if (div_zero_c) begin
         cnt_d = '0;
         if (pend_q) begin
            active_d = shadow_q;
            if (!wr_hit) begin
               pend_d = 1'b0;
            end
         end
      end else if (clr) begin
         cnt_d = '0;
      end else if (term_c) begin
         cnt_d  = '0;
         tick_d = 1'b1;
         sq_d   = ~sq_q;
         if (wr_hit) begin
            active_d = wr_div;
            pend_d   = 1'b0;
         end else if (pend_q) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
         end
      end else if (in_en) begin
         cnt_d = cnt_q + DIV_W'(1);
      end

      if (clr) begin
         cnt_d  = '0;
         tick_d = 1'b0;
         sq_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         active_q <= rst_div;
         shadow_q <= rst_div;
         pend_q   <= 1'b0;
         tick_q   <= 1'b0;
         sq_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         active_q <= active_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         tick_q   <= tick_d;
         sq_q     <= sq_d;
      end
   end

   assign tick = tick_q;
   assign sq   = sq_q;

endmodule

// File: rtl/clkdiv_cascade.sv
// Programmable cascade of clock-enable dividers; stage k is clocked by stage k-1 ticks.
// Build option CLKDIV_IMM_LOAD_EN adds the wr_imm port for immediate divisor loads.
module clkdiv_cascade
   import clkdiv_pkg::*;
#(
   parameter int unsigned             NUM_CH      = 3,
   parameter int unsigned             DIV_W       = CLKDIV_DIV_W,
   parameter logic [NUM_CH*DIV_W-1:0] DIV_DEFAULT = {NUM_CH{DIV_W'(1000)}}
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    en,
   input  logic                                    clr,
   input  logic                                    wr_en,
   input  logic [clkdiv_pkg::wr_ch_w(NUM_CH)-1:0]  wr_ch,
   input  logic [DIV_W-1:0]                        wr_div,
`ifdef CLKDIV_IMM_LOAD_EN
   input  logic                                    wr_imm,
`endif
   output logic [NUM_CH-1:0]                       tick,
   output logic [NUM_CH-1:0]                       sq
);

   localparam int unsigned WCH_W = wr_ch_w(NUM_CH);

   logic [NUM_CH-1:0] in_en_c;
   logic [NUM_CH-1:0] wr_hit_c;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      // Out-of-range channel indices match no stage and are dropped.
      assign wr_hit_c[k] = wr_en && (wr_ch == WCH_W'(k));

      if (k == 0) begin : g_head
         assign in_en_c[k] = en;
      end else begin : g_tail
         assign in_en_c[k] = tick[k-1];
      end

      clkdiv_stage #(
         .DIV_W (DIV_W)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .clr     (clr),
         .in_en   (in_en_c[k]),
         .wr_hit  (wr_hit_c[k]),
`ifdef CLKDIV_IMM_LOAD_EN
         .wr_imm  (wr_imm),
`endif
         .wr_div  (wr_div),
         .rst_div (DIV_DEFAULT[k*DIV_W +: DIV_W]),
         .tick    (tick[k]),
         .sq      (sq[k])
      );
   end

endmodule

// File: tb/tb_clkdiv_cascade.sv
// Directed self-checking bench for clkdiv_cascade (NUM_CH=2, reset divisors {3,4}).
// Exercises the CLKDIV_IMM_LOAD_EN path only when that macro is defined.
module tb_clkdiv_cascade;

   localparam int unsigned NUM_CH = 2;
   localparam int unsigned DIV_W  = 24;
   localparam int unsigned WCH_W  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic              clr;
   logic              wr_en;
   logic [WCH_W-1:0]  wr_ch;
   logic [DIV_W-1:0]  wr_div;
`ifdef CLKDIV_IMM_LOAD_EN
   logic              wr_imm;
`endif
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] sq;

   int n_checks = 0;
   int n_fail   = 0;

   clkdiv_cascade #(
      .NUM_CH      (NUM_CH),
      .DIV_W       (DIV_W),
      .DIV_DEFAULT ({24'd3, 24'd4})
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .clr    (clr),
      .wr_en  (wr_en),
      .wr_ch  (wr_ch),
      .wr_div (wr_div),
`ifdef CLKDIV_IMM_LOAD_EN
      .wr_imm (wr_imm),
`endif
      .tick   (tick),
      .sq     (sq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clr    = 1'b0;
      wr_en  = 1'b0;
      wr_ch  = '0;
      wr_div = '0;
`ifdef CLKDIV_IMM_LOAD_EN
      wr_imm = 1'b0;
`endif
   endtask

   // Leaves the bench at sample point s0 with en=1 driven.
   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b0;
      idle_inputs();
      step();
      step();
      rst = 1'b0;
      en  = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b1;
      idle_inputs();
      step();
      step();
      n_checks++;
      if (tick !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_tick: got %b expected 00", tick);
      end
      n_checks++;
      if (sq !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_sq: got %b expected 00", sq);
      end
   endtask

   task automatic test_cascade();
      logic [23:0] t0, t1, s0;
      do_reset();
      for (int i = 0; i < 24; i++) begin
         step();
         t0[i] = tick[0];
         t1[i] = tick[1];
         s0[i] = sq[0];
      end
      n_checks++;
      if (t0 !== 24'h888888) begin
         n_fail++;
         $display("FAIL cascade_tick0: got %h expected 888888", t0);
      end
      n_checks++;
      if (t1 !== 24'h001000) begin
         n_fail++;
         $display("FAIL cascade_tick1: got %h expected 001000", t1);
      end
      n_checks++;
      if (s0 !== 24'h787878) begin
         n_fail++;
         $display("FAIL cascade_sq0: got %h expected 787878", s0);
      end
      n_checks++;
      if (sq[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL cascade_sq1: got %b expected 1", sq[1]);
      end
   endtask

   task automatic test_deferred_write();
      logic [13:0] t0, s0;
      do_reset();
      step();
      step();
      wr_en  = 1'b1;
      wr_ch  = 2'd0;
      wr_div = 24'd5;
      step();
      wr_en  = 1'b0;
      t0[0]  = tick[0];
      s0[0]  = sq[0];
      for (int i = 1; i < 14; i++) begin
         step();
         t0[i] = tick[0];
         s0[i] = sq[0];
      end
      n_checks++;
      if (t0 !== 14'h0842) begin
         n_fail++;
         $display("FAIL deferred_tick0: got %h expected 0842", t0);
      end
      n_checks++;
      if (s0 !== 14'h383e) begin
         n_fail++;
         $display("FAIL deferred_sq0: got %h expected 383e", s0);
      end
   endtask

   task automatic test_boundaries();
      logic [5:0]        t0, t1, s0, r0;
      logic [NUM_CH-1:0] acc;
      do_reset();
      wr_en  = 1'b1;
      wr_ch  = 2'd0;
      wr_div = 24'd1;
      step();
      wr_en  = 1'b0;
      step();
      step();
      for (int i = 0; i < 6; i++) begin
         step();
         t0[i] = tick[0];
         t1[i] = tick[1];
         s0[i] = sq[0];
      end
      n_checks++;
      if (t0 !== 6'b111111) begin
         n_fail++;
         $display("FAIL d1_tick0: got %b expected 111111", t0);
      end
      n_checks++;
      if (s0 !== 6'b010101) begin
         n_fail++;
         $display("FAIL d1_sq0: got %b expected 010101", s0);
      end
      n_checks++;
      if (t1 !== 6'b001000) begin
         n_fail++;
         $display("FAIL d1_tick1: got %b expected 001000", t1);
      end
      // Divisor 0 lands on a terminal count, so it bypasses straight in.
      wr_en  = 1'b1;
      wr_div = 24'd0;
      step();
      wr_en  = 1'b0;
      acc    = '0;
      for (int i = 0; i < 10; i++) begin
         step();
         acc = acc | tick;
      end
      n_checks++;
      if (acc !== 2'b00) begin
         n_fail++;
         $display("FAIL d0_stall: got tick or %b expected 00", acc);
      end
      n_checks++;
      if (sq[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL d0_sq_hold: got %b expected 1", sq[0]);
      end
      wr_en  = 1'b1;
      wr_div = 24'd2;
      step();
      wr_en  = 1'b0;
      r0[0]  = tick[0];
      for (int i = 1; i < 6; i++) begin
         step();
         r0[i] = tick[0];
      end
      n_checks++;
      if (r0 !== 6'b101000) begin
         n_fail++;
         $display("FAIL d2_resume: got %b expected 101000", r0);
      end
   endtask

   task automatic test_en_clr();
      logic [10:0] t0;
      logic [3:0]  t1;
      do_reset();
      step();
      en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step();
         t0[i] = tick[0];
      end
      en = 1'b1;
      for (int i = 7; i < 11; i++) begin
         step();
         t0[i] = tick[0];
      end
      n_checks++;
      if (t0 !== 11'h200) begin
         n_fail++;
         $display("FAIL en_freeze_tick0: got %h expected 200", t0);
      end
      n_checks++;
      if (sq[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL en_freeze_sq0: got %b expected 1", sq[0]);
      end
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      n_checks++;
      if ({tick, sq} !== 4'b0000) begin
         n_fail++;
         $display("FAIL clr_outputs: got tick %b sq %b expected 00 00", tick, sq);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         t1[i] = tick[0];
      end
      n_checks++;
      if (t1 !== 4'b1000) begin
         n_fail++;
         $display("FAIL clr_restart: got %b expected 1000", t1);
      end
   endtask

   task automatic test_bypass_ignore_rst();
      logic [5:0] b0;
      logic [7:0] g0, r0;
      do_reset();
      step();
      step();
      step();
      wr_en  = 1'b1;
      wr_ch  = 2'd0;
      wr_div = 24'd2;
      step();
      wr_en  = 1'b0;
      b0[0]  = tick[0];
      for (int i = 1; i < 6; i++) begin
         step();
         b0[i] = tick[0];
      end
      n_checks++;
      if (b0 !== 6'b010101) begin
         n_fail++;
         $display("FAIL bypass_tick0: got %b expected 010101", b0);
      end
      wr_en  = 1'b1;
      wr_ch  = 2'd2;
      wr_div = 24'd7;
      step();
      wr_en  = 1'b0;
      g0[0]  = tick[0];
      for (int i = 1; i < 8; i++) begin
         step();
         g0[i] = tick[0];
      end
      n_checks++;
      if (g0 !== 8'b01010101) begin
         n_fail++;
         $display("FAIL bad_ch_ignored: got %b expected 01010101", g0);
      end
      rst    = 1'b1;
      wr_en  = 1'b1;
      wr_ch  = 2'd0;
      wr_div = 24'd9;
      step();
      rst    = 1'b0;
      wr_en  = 1'b0;
      n_checks++;
      if ({tick, sq} !== 4'b0000) begin
         n_fail++;
         $display("FAIL rst_wr_outputs: got tick %b sq %b expected 00 00", tick, sq);
      end
      for (int i = 0; i < 8; i++) begin
         step();
         r0[i] = tick[0];
      end
      n_checks++;
      if (r0 !== 8'b10001000) begin
         n_fail++;
         $display("FAIL rst_wr_lost: got %b expected 10001000", r0);
      end
   endtask

`ifdef CLKDIV_IMM_LOAD_EN
   task automatic test_imm_load();
      logic [5:0] t0;
      do_reset();
      wr_en  = 1'b1;
      wr_ch  = 2'd0;
      wr_div = 24'd10;
      step();
      wr_en  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
      end
      wr_en  = 1'b1;
      wr_imm = 1'b1;
      wr_div = 24'd2;
      step();
      wr_en  = 1'b0;
      wr_imm = 1'b0;
      t0[0]  = tick[0];
      for (int i = 1; i < 6; i++) begin
         step();
         t0[i] = tick[0];
      end
      n_checks++;
      if (t0 !== 6'b010100) begin
         n_fail++;
         $display("FAIL imm_load_tick0: got %b expected 010100", t0);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      idle_inputs();
      test_reset();
      test_cascade();
      test_deferred_write();
      test_boundaries();
      test_en_clr();
      test_bypass_ignore_rst();
`ifdef CLKDIV_IMM_LOAD_EN
      test_imm_load();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
